// File: rtl/bpu_gshare_if.sv
// bpu_gshare_if: fetch-lookup, branch-resolve and prediction bundle
// master = IFU/ALU side, slave = predictor
interface bpu_gshare_if #(
  parameter int XLEN  = 64,
  parameter int GHR_W = 8
);
  logic             ifu_bpu_pc_valid;
  logic [XLEN-1:0]  ifu_bpu_pc;
  logic             alu_bpu_wr_req;
  logic [XLEN-1:0]  alu_bpu_wr_pc;
  logic [2:0]       alu_bpu_wr_type;
  logic [XLEN-1:0]  alu_bpu_wr_target;
  logic             alu_bpu_wr_taken;
  logic [GHR_W-1:0] alu_bpu_wr_ghr;
  logic             alu_bpu_mispredict;
  logic             bpu_ifu_predict_vld;
  logic [XLEN-1:0]  bpu_ifu_next_pc;
  logic             bpu_ifu_predict_hit;
  logic             bpu_ifu_predict_taken;
  logic [XLEN-1:0]  bpu_ifu_predict_pc;
  logic [GHR_W-1:0] bpu_ifu_ghr;

  modport master (
    output ifu_bpu_pc_valid, ifu_bpu_pc,
    output alu_bpu_wr_req, alu_bpu_wr_pc,
    output alu_bpu_wr_type, alu_bpu_wr_target,
    output alu_bpu_wr_taken, alu_bpu_wr_ghr,
    output alu_bpu_mispredict,
    input  bpu_ifu_predict_vld, bpu_ifu_next_pc,
    input  bpu_ifu_predict_hit, bpu_ifu_predict_taken,
    input  bpu_ifu_predict_pc, bpu_ifu_ghr
  );

  modport slave (
    input  ifu_bpu_pc_valid, ifu_bpu_pc,
    input  alu_bpu_wr_req, alu_bpu_wr_pc,
    input  alu_bpu_wr_type, alu_bpu_wr_target,
    input  alu_bpu_wr_taken, alu_bpu_wr_ghr,
    input  alu_bpu_mispredict,
    output bpu_ifu_predict_vld, bpu_ifu_next_pc,
    output bpu_ifu_predict_hit, bpu_ifu_predict_taken,
    output bpu_ifu_predict_pc, bpu_ifu_ghr
  );
endinterface

// File: rtl/bpu_gshare.sv
// bpu_gshare: direct-mapped BTB + gshare PHT, 1-cycle lookup
// ports: clk, rstn (async low), bus (bpu_gshare_if.slave)
// optional return stack: define BPU_RAS_EN
module bpu_gshare #(
  parameter int XLEN      = 64,
  parameter int BTB_DEPTH = 16,
  parameter int PHT_DEPTH = 256,
  parameter int GHR_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input logic         clk,
  input logic         rstn,
  bpu_gshare_if.slave bus
);

  localparam int BI = $clog2(BTB_DEPTH);
  localparam int PI = $clog2(PHT_DEPTH);
  localparam int TW = XLEN - BI - 2;

  localparam logic [2:0] T_BR   = 3'd1;
  localparam logic [2:0] T_CALL = 3'd4;
  localparam logic [2:0] T_RET  = 3'd5;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic            btb_vld  [BTB_DEPTH];
  logic [TW-1:0]   btb_tag  [BTB_DEPTH];
  logic [2:0]      btb_type [BTB_DEPTH];
  logic [XLEN-1:0] btb_tgt  [BTB_DEPTH];
  logic [1:0]      pht      [PHT_DEPTH];
  logic [GHR_W-1:0] ghr;

  logic            o_vld;
  logic [XLEN-1:0] o_npc;
  logic            o_hit;
  logic            o_taken;
  logic [XLEN-1:0] o_ppc;
  logic [GHR_W-1:0] o_ghr;

  logic            l_vld;
  logic [XLEN-1:0] l_pc;
  logic [BI-1:0]   l_bidx;
  logic [TW-1:0]   l_tag;
  logic [PI-1:0]   l_pidx;
  logic            l_hit;
  logic [2:0]      l_type;
  logic            l_taken;
  logic [XLEN-1:0] l_tgt;
  logic [XLEN-1:0] l_pc4;
  logic            l_br;

  logic            w_req;
  logic [2:0]      w_type;
  logic            w_ok;
  logic            w_br;
  logic [BI-1:0]   w_bidx;
  logic [TW-1:0]   w_tag;
  logic [PI-1:0]   w_pidx;
  logic            recover;
  logic [GHR_W-1:0] rec_ghr;

  logic unused_bits;

  assign l_vld  = bus.ifu_bpu_pc_valid;
  assign l_pc   = bus.ifu_bpu_pc;
  assign l_bidx = l_pc[BI+1:2];
  assign l_tag  = l_pc[XLEN-1:BI+2];
  assign l_pidx = l_pc[PI+1:2] ^ PI'(ghr);
  assign l_hit  = btb_vld[l_bidx] &&
                  (btb_tag[l_bidx] == l_tag);
  assign l_type = btb_type[l_bidx];
  assign l_pc4  = l_pc + FOUR;
  assign l_br   = l_vld && l_hit &&
                  (l_type == T_BR);

  assign w_req  = bus.alu_bpu_wr_req;
  assign w_type = bus.alu_bpu_wr_type;
  assign w_ok   = w_req && (w_type >= 3'd1) &&
                  (w_type <= 3'd5);
  assign w_br   = w_ok && (w_type == T_BR);
  assign w_bidx = bus.alu_bpu_wr_pc[BI+1:2];
  assign w_tag  = bus.alu_bpu_wr_pc[XLEN-1:BI+2];
  assign w_pidx = bus.alu_bpu_wr_pc[PI+1:2] ^
                  PI'(bus.alu_bpu_wr_ghr);
  assign recover = w_req && bus.alu_bpu_mispredict;
  assign rec_ghr = (w_type == T_BR) ?
    {bus.alu_bpu_wr_ghr[GHR_W-2:0],
     bus.alu_bpu_wr_taken} :
    bus.alu_bpu_wr_ghr;

  assign unused_bits = ^{bus.ifu_bpu_pc[1:0],
                         bus.alu_bpu_wr_pc[1:0]};

`ifdef BPU_RAS_EN
  localparam int RW = (RAS_DEPTH > 1) ?
                      $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [RW-1:0]   ras_top;
  logic [CW-1:0]   ras_cnt;
  logic [RW-1:0]   ras_nxt;
  logic [RW-1:0]   ras_prv;
  logic            ras_push;
  logic            ras_pop;

  assign ras_nxt = (ras_top == RW'(RAS_DEPTH - 1)) ?
                   '0 : ras_top + RW'(1);
  assign ras_prv = (ras_top == '0) ?
                   RW'(RAS_DEPTH - 1) : ras_top - RW'(1);
  assign ras_push = l_vld && l_hit && (l_type == T_CALL);
  assign ras_pop  = l_vld && l_hit && (l_type == T_RET) &&
                    (ras_cnt != '0);

  // oldest entry is silently overwritten once full
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ras_top <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_top <= ras_nxt;
      if (ras_cnt != CW'(RAS_DEPTH))
        ras_cnt <= ras_cnt + CW'(1);
    end else if (ras_pop) begin
      ras_top <= ras_prv;
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push)
      ras_mem[ras_nxt] <= l_pc4;
  end
`endif

  always_comb begin
    l_taken = 1'b0;
    l_tgt   = '0;
    if (l_hit) begin
      l_tgt = btb_tgt[l_bidx];
      unique case (1'b1)
        (l_type == T_BR): l_taken = pht[l_pidx][1];
`ifdef BPU_RAS_EN
        (l_type == T_RET): begin
          l_taken = 1'b1;
          if (ras_cnt != '0)
            l_tgt = ras_mem[ras_top];
        end
`endif
        default: l_taken = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_vld   <= 1'b0;
      o_npc   <= '0;
      o_hit   <= 1'b0;
      o_taken <= 1'b0;
      o_ppc   <= '0;
      o_ghr   <= '0;
    end else begin
      o_vld <= l_vld;
      if (l_vld) begin
        o_hit   <= l_hit;
        o_taken <= l_taken;
        o_ppc   <= l_tgt;
        o_npc   <= l_taken ? l_tgt : l_pc4;
        o_ghr   <= ghr;
      end
    end
  end

  // recovery wins over the speculative shift
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ghr <= '0;
    else if (recover)
      ghr <= rec_ghr;
    else if (l_br)
      ghr <= {ghr[GHR_W-2:0], l_taken};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BTB_DEPTH; i++)
        btb_vld[i] <= 1'b0;
    end else if (w_ok) begin
      btb_vld[w_bidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ok) begin
      btb_tag[w_bidx]  <= w_tag;
      btb_type[w_bidx] <= w_type;
      btb_tgt[w_bidx]  <= bus.alu_bpu_wr_target;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PHT_DEPTH; i++)
        pht[i] <= 2'b01;
    end else if (w_br) begin
      if (bus.alu_bpu_wr_taken) begin
        if (pht[w_pidx] != 2'b11)
          pht[w_pidx] <= pht[w_pidx] + 2'd1;
      end else if (pht[w_pidx] != 2'b00) begin
        pht[w_pidx] <= pht[w_pidx] - 2'd1;
      end
    end
  end

  assign bus.bpu_ifu_predict_vld   = o_vld;
  assign bus.bpu_ifu_next_pc       = o_npc;
  assign bus.bpu_ifu_predict_hit   = o_hit;
  assign bus.bpu_ifu_predict_taken = o_taken;
  assign bus.bpu_ifu_predict_pc    = o_ppc;
  assign bus.bpu_ifu_ghr           = o_ghr;

endmodule

// File: tb/tb_bpu_gshare.sv
// tb_bpu_gshare: random + directed check of bpu_gshare
// against a table/queue model of the predictor
module tb_bpu_gshare;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bpu_gshare_if #(.XLEN(64), .GHR_W(8)) bus ();

  bpu_gshare dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  bit          m_vld [16];
  logic [63:0] m_tag [16];
  int          m_typ [16];
  logic [63:0] m_tgt [16];
  int          m_pht [256];
  int          m_ghr;
  logic [63:0] m_ras [$];

  bit          e_vld;
  bit          e_hit;
  bit          e_tk;
  logic [63:0] e_npc;
  logic [63:0] e_ppc;
  int          e_ghr;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_vld[i] = 0;
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_ras.delete();
    e_vld = 0; e_hit = 0; e_tk = 0;
    e_npc = 0; e_ppc = 0; e_ghr = 0;
  endtask

  always @(negedge clk) begin
    chk("vld",   64'(bus.bpu_ifu_predict_vld), 64'(e_vld));
    chk("hit",   64'(bus.bpu_ifu_predict_hit), 64'(e_hit));
    chk("taken", 64'(bus.bpu_ifu_predict_taken), 64'(e_tk));
    chk("npc",   bus.bpu_ifu_next_pc, e_npc);
    chk("ppc",   bus.bpu_ifu_predict_pc, e_ppc);
    chk("ghr",   64'(bus.bpu_ifu_ghr), 64'(e_ghr));
  end

  // called at a negedge; returns at the following negedge
  task automatic cyc(input bit v, input logic [63:0] pc,
                     input bit wr, input logic [63:0] wpc,
                     input logic [2:0] wt,
                     input logic [63:0] wtg, input bit wtk,
                     input logic [7:0] wg, input bit mp);
    int bi, pi, wb, wp, ty;
    bit hit, tk;
    logic [63:0] tgt;
    bus.ifu_bpu_pc_valid   = v;
    bus.ifu_bpu_pc         = pc;
    bus.alu_bpu_wr_req     = wr;
    bus.alu_bpu_wr_pc      = wpc;
    bus.alu_bpu_wr_type    = wt;
    bus.alu_bpu_wr_target  = wtg;
    bus.alu_bpu_wr_taken   = wtk;
    bus.alu_bpu_wr_ghr     = wg;
    bus.alu_bpu_mispredict = mp;
    bi  = int'((pc >> 2) % 16);
    pi  = int'((pc >> 2) % 256) ^ m_ghr;
    hit = m_vld[bi] && (m_tag[bi] == (pc >> 6));
    ty  = hit ? m_typ[bi] : 0;
    tk  = 0;
    tgt = 0;
    if (hit) begin
      tgt = m_tgt[bi];
      tk  = (ty == 1) ? (m_pht[pi] >= 2) : 1'b1;
`ifdef BPU_RAS_EN
      if (ty == 5 && m_ras.size() > 0) tgt = m_ras[$];
`endif
    end
    @(posedge clk);
    e_vld = v;
    if (v) begin
      e_hit = hit;
      e_tk  = tk;
      e_ppc = tgt;
      e_npc = tk ? tgt : pc + 64'd4;
      e_ghr = m_ghr;
    end
    if (wr && mp)
      m_ghr = (wt == 3'd1) ?
              (((int'(wg) << 1) | int'(wtk)) & 255) : int'(wg);
    else if (v && ty == 1)
      m_ghr = ((m_ghr << 1) | int'(tk)) & 255;
`ifdef BPU_RAS_EN
    if (v && ty == 4) begin
      m_ras.push_back(pc + 64'd4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
    if (v && ty == 5 && m_ras.size() > 0)
      void'(m_ras.pop_back());
`endif
    if (wr && wt >= 3'd1 && wt <= 3'd5) begin
      wb = int'((wpc >> 2) % 16);
      m_vld[wb] = 1;
      m_tag[wb] = wpc >> 6;
      m_typ[wb] = int'(wt);
      m_tgt[wb] = wtg;
      if (wt == 3'd1) begin
        wp = int'((wpc >> 2) % 256) ^ int'(wg);
        if (wtk && m_pht[wp] < 3) m_pht[wp]++;
        if (!wtk && m_pht[wp] > 0) m_pht[wp]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic look(input logic [63:0] pc);
    cyc(1, pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [63:0] pc,
                     input logic [2:0] t,
                     input logic [63:0] tg,
                     input bit tk, input logic [7:0] g);
    cyc(0, 0, 1, pc, t, tg, tk, g, 0);
  endtask

  task automatic rnd(input int n);
    logic [63:0] pc, wpc;
    for (int i = 0; i < n; i++) begin
      pc  = 64'h1000 + 64'(4 * $urandom_range(0, 63));
      wpc = 64'h1000 + 64'(4 * $urandom_range(0, 63));
      cyc($urandom_range(0, 9) < 7, pc,
          $urandom_range(0, 1) == 1, wpc,
          3'($urandom_range(0, 7)),
          {$urandom, $urandom}, 1'($urandom),
          8'($urandom), $urandom_range(0, 4) == 0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    bus.ifu_bpu_pc_valid = 0; bus.ifu_bpu_pc = 0;
    bus.alu_bpu_wr_req = 0; bus.alu_bpu_wr_pc = 0;
    bus.alu_bpu_wr_type = 0; bus.alu_bpu_wr_target = 0;
    bus.alu_bpu_wr_taken = 0; bus.alu_bpu_wr_ghr = 0;
    bus.alu_bpu_mispredict = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_npc", bus.bpu_ifu_next_pc, 64'h0);
    chk("rst_vld", 64'(bus.bpu_ifu_predict_vld), 64'h0);
    rstn = 1'b1;

    look(64'h1000);
    chk("r032_vld", 64'(bus.bpu_ifu_predict_vld), 64'h1);
    chk("r032_hit", 64'(bus.bpu_ifu_predict_hit), 64'h0);
    chk("r032_npc", bus.bpu_ifu_next_pc, 64'h1004);

    upd(64'h1000, 3'd2, 64'h2000, 1, 8'h00);
    look(64'h1000);
    chk("r033_hit", 64'(bus.bpu_ifu_predict_hit), 64'h1);
    chk("r033_npc", bus.bpu_ifu_next_pc, 64'h2000);
    look(64'h1040);
    chk("r033_alias", 64'(bus.bpu_ifu_predict_hit), 64'h0);
    chk("r033_appc", bus.bpu_ifu_predict_pc, 64'h0);

    upd(64'h3000, 3'd1, 64'h3100, 1, 8'h00);
    upd(64'h3000, 3'd1, 64'h3100, 1, 8'h00);
    look(64'h3000);
    chk("r034_tk", 64'(bus.bpu_ifu_predict_taken), 64'h1);
    chk("r034_npc", bus.bpu_ifu_next_pc, 64'h3100);
    look(64'h2000);
    chk("r034_ghr", 64'(bus.bpu_ifu_ghr), 64'h01);

    for (int i = 0; i < 4; i++)
      upd(64'h5020, 3'd1, 64'h5800, 0, 8'h01);
    upd(64'h5020, 3'd1, 64'h5800, 1, 8'h01);
    look(64'h5020);
    chk("r035_hit", 64'(bus.bpu_ifu_predict_hit), 64'h1);
    chk("r035_tk", 64'(bus.bpu_ifu_predict_taken), 64'h0);
    chk("r035_npc", bus.bpu_ifu_next_pc, 64'h5024);

    cyc(1, 64'h3000, 1, 64'h3000, 3'd1, 64'h3100,
        1, 8'h5A, 1);
    chk("r036_lghr", 64'(bus.bpu_ifu_ghr), 64'h02);
    chk("r036_lnpc", bus.bpu_ifu_next_pc, 64'h3004);
    look(64'h2000);
    chk("r036_ghr", 64'(bus.bpu_ifu_ghr), 64'hB5);

    look(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_npc", bus.bpu_ifu_next_pc, 64'h0);

    upd(64'h7000, 3'd6, 64'h7700, 0, 8'h00);
    look(64'h7000);
    chk("badtype_hit", 64'(bus.bpu_ifu_predict_hit), 64'h0);

    upd(64'h4000, 3'd4, 64'h8000, 0, 8'h00);
    upd(64'h6004, 3'd5, 64'h9000, 0, 8'h00);
    look(64'h4000);
    chk("call_npc", bus.bpu_ifu_next_pc, 64'h8000);
    look(64'h6004);
`ifdef BPU_RAS_EN
    chk("ret_npc", bus.bpu_ifu_next_pc, 64'h4004);
    for (int k = 1; k <= 5; k++)
      upd(64'h4000 + 64'(8 * k), 3'd4, 64'h8000, 0, 8'h00);
    for (int k = 1; k <= 5; k++)
      look(64'h4000 + 64'(8 * k));
    for (int k = 5; k >= 2; k--) begin
      look(64'h6004);
      chk("ras_pop", bus.bpu_ifu_next_pc,
          64'h4004 + 64'(8 * k));
    end
    look(64'h6004);
    chk("ras_empty", bus.bpu_ifu_next_pc, 64'h9000);
`else
    chk("ret_npc", bus.bpu_ifu_next_pc, 64'h9000);
`endif

    rnd(2000);

    look(64'h1000);
    #2 rstn = 1'b0;
    #1;
    chk("arst_vld", 64'(bus.bpu_ifu_predict_vld), 64'h0);
    chk("arst_npc", bus.bpu_ifu_next_pc, 64'h0);
    model_reset();
    bus.ifu_bpu_pc_valid = 0;
    bus.alu_bpu_wr_req = 0;
    @(negedge clk);
    rstn = 1'b1;
    look(64'h1000);
    chk("arst_hit", 64'(bus.bpu_ifu_predict_hit), 64'h0);

    rnd(1000);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bpu_gshare.md
BPU_GSHARE -- requirements
Module: bpu_gshare

Interface
REQ-001 Parameters: XLEN default 64, address width; BTB_DEPTH default 16, BTB entries, power of 2; PHT_DEPTH default 256, 2-bit counters, power of 2; GHR_W default 8, global history bits, no larger than log2(PHT_DEPTH); RAS_DEPTH default 4, return stack entries.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 ifu_bpu_pc_valid  in  1  lookup request this cycle.
REQ-005 ifu_bpu_pc  in  XLEN  lookup PC.
REQ-006 alu_bpu_wr_req  in  1  resolved-branch update strobe.
REQ-007 alu_bpu_wr_pc  in  XLEN  resolved instruction PC.
REQ-008 alu_bpu_wr_type  in  3  1=branch, 2=jal, 3=jalr, 4=call, 5=ret; others are ignored and cause no write.
REQ-009 alu_bpu_wr_target  in  XLEN  resolved target.
REQ-010 alu_bpu_wr_taken  in  1  resolved direction.
REQ-011 alu_bpu_wr_ghr  in  GHR_W  GHR snapshot carried with the instruction.
REQ-012 alu_bpu_mispredict  in  1  redirect/flush; qualified by alu_bpu_wr_req.
REQ-013 bpu_ifu_predict_vld  out  1  registered ifu_bpu_pc_valid.
REQ-014 bpu_ifu_next_pc  out  XLEN  predicted fetch PC.
REQ-015 bpu_ifu_predict_hit  out  1  BTB hit.
REQ-016 bpu_ifu_predict_taken  out  1  predicted taken.
REQ-017 bpu_ifu_predict_pc  out  XLEN  predicted target, zero when there is no hit.
REQ-018 bpu_ifu_ghr  out  GHR_W  GHR value used for this prediction.

Function
REQ-019 Lookup latency is 1 cycle: a request at edge N produces outputs after edge N+1, and the outputs hold until the next valid lookup.
REQ-020 The BTB is direct-mapped.
- Index: PC[log2(BTB_DEPTH)+1:2].
- Tag: the remaining upper PC bits.
- Entry: valid, tag, type, target.
REQ-021 PHT index = PC[log2(PHT_DEPTH)+1:2] XOR the GHR zero-extended. A counter bit[1]=1 predicts taken.
REQ-022 Prediction on a hit:
- type 2 or 4: taken, target from the BTB.
- type 1: taken if the counter MSB is set.
- type 3: taken, target from the BTB.
- type 5: see REQ-031.
- On a miss: not taken, next_pc = PC+4.
REQ-023 next_pc = predicted target when taken, else PC+4, with modulo-2^XLEN wrap.
REQ-024 Speculative GHR: on a valid lookup that hits type 1, the GHR becomes {GHR[GHR_W-2:0], predicted taken} at edge N+1.
REQ-025 Update, on alu_bpu_wr_req with a valid type: write the BTB entry as valid, with tag, type and target.
REQ-026 PHT update, type 1 only: at index alu_bpu_wr_pc XOR alu_bpu_wr_ghr, increment the counter if taken, else decrement. Counters saturate at 0 and 3.
REQ-027 Recovery: on alu_bpu_wr_req & alu_bpu_mispredict, the GHR is set as follows:
- type 1: {wr_ghr[GHR_W-2:0], wr_taken}.
- other types: wr_ghr.
Recovery overrides any speculative GHR update in the same cycle.
REQ-028 A lookup and an update to the same BTB/PHT entry in the same cycle return the old contents; there is no bypass.
REQ-029 A lookup in the same cycle as a mispredict is still answered, using the pre-recovery GHR.

Reset
REQ-030 On assertion of rstn low, independent of clk:
- All BTB valid bits = 0.
- PHT counters = 2'b01.
- GHR = 0.
- RAS empty.
- All outputs = 0, including next_pc = 0.
The block leaves reset on the first edge after rstn goes high. An in-flight lookup is discarded.

Configuration
REQ-031 Macro BPU_RAS_EN.
- When defined: a circular RAS of RAS_DEPTH entries.
- A predicted call hit pushes PC+4.
- A predicted ret hit pops; the target is the top of stack, and the BTB target is used if the stack is empty.
- Push when full overwrites the oldest entry; the count saturates at RAS_DEPTH.
- Pop when empty leaves the count at 0.
- Mispredict leaves the RAS unchanged.
- Push and pop never occur in the same cycle.
- When undefined: no RAS storage exists; type 5 behaves as type 3, and type 4 behaves as type 2.

Verification
REQ-032 Reset, then lookup 0x1000 -> next cycle: vld=1, hit=0, taken=0, next_pc=0x1004, ghr=0.
REQ-033 Update type 2, pc 0x1000, target 0x2000; lookup 0x1000 -> hit=1, taken=1, next_pc=0x2000; lookup 0x1040, same index but different tag -> hit=0.
REQ-034 Update type 1, pc 0x3000, taken=1, ghr=0, twice; lookup 0x3000 with GHR=0 -> taken=1, and the GHR then reads 0x01.
REQ-035 Four not-taken updates at the same PHT index -> the counter saturates at 0; one taken update -> 1, still predicts not taken.
REQ-036 Mispredict type 1, wr_ghr=0x5A, taken=1, in the same cycle as a hitting branch lookup -> GHR=0xB5.
REQ-037 With BPU_RAS_EN defined:
- Call at 0x4000 pushes 0x4004.
- A ret lookup then gives next_pc=0x4004.
- Five calls with RAS_DEPTH=4 followed by four rets return the four most recent return addresses.
